// File: rtl/pixel_write_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_write_arbiter
//
// Shares the single VGA adapter write port among NUM_CLIENTS pixel-draw
// engines (coin eraser, player sprite, ghost sprite, background redraw).
// Each client offers one pixel per request using a req/grant handshake. A
// round-robin pointer picks the next client after the last one accepted, so
// no engine starves. The screen controller can stall all grants with hold.
// The accepted pixel is registered and drives the VGA adapter directly.
// Pixels outside the XMAX x YMAX screen are still accepted and their
// coordinates captured, but they do not plot. Instead they bump a saturating
// drop counter.
//
// Optional feature (macro PIXEL_ARB_LOCK_EN):
//   Adds a per-client lock input. A beat accepted with its lock bit set
//   reserves the port for that client. Multi-pixel sprites are then drawn
//   atomically, until the owner samples its lock bit low.
//
// Ports:
//   clock     in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   hold      in   1 = issue no grants
//   req       in   per-client pixel request (bit i = client i)
//   lock      in   per-client lock request (only with PIXEL_ARB_LOCK_EN)
//   iX        in   packed x, client i at [i*XW +: XW]
//   iY        in   packed y, client i at [i*YW +: YW]
//   iColour   in   packed colour, client i at [i*CW +: CW]
//   grant     out  one-hot-or-zero grant (combinational)
//   oX        out  registered x to VGA
//   oY        out  registered y to VGA
//   oColour   out  registered colour to VGA
//   oPlot     out  registered write strobe to VGA
//   dropCount out  saturating count of accepted off-screen pixels
// -----------------------------------------------------------------------------
module pixel_write_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int CW          = 9,
    parameter int XMAX        = 160,
    parameter int YMAX        = 120
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      hold,
    input  logic [NUM_CLIENTS-1:0]    req,
`ifdef PIXEL_ARB_LOCK_EN
    input  logic [NUM_CLIENTS-1:0]    lock,
`endif
    input  logic [NUM_CLIENTS*XW-1:0] iX,
    input  logic [NUM_CLIENTS*YW-1:0] iY,
    input  logic [NUM_CLIENTS*CW-1:0] iColour,
    output logic [NUM_CLIENTS-1:0]    grant,
    output logic [XW-1:0]             oX,
    output logic [YW-1:0]             oY,
    output logic [CW-1:0]             oColour,
    output logic                      oPlot,
    output logic [7:0]                dropCount
);

    localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    // On-screen test. It uses 32-bit unsigned compares, so XMAX/YMAX may
    // equal 2**XW / 2**YW without overflowing.
    function automatic logic on_screen(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (32'(x) < 32'(XMAX)) && (32'(y) < 32'(YMAX));
    endfunction

    // Architectural state
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [XW-1:0] ox_q,    ox_d;
    logic [YW-1:0] oy_q,    oy_d;
    logic [CW-1:0] ocol_q,  ocol_d;
    logic          plot_q,  plot_d;
    logic [7:0]    drop_q,  drop_d;
`ifdef PIXEL_ARB_LOCK_EN
    logic          locked_q, locked_d;
    logic [PW-1:0] owner_q,  owner_d;
`endif

    // Arbitration results
    logic [NUM_CLIENTS-1:0] grant_s;
    logic                   acc_s;
    logic [PW-1:0]          acc_idx_s;
    logic [PW-1:0]          cand_s;
    logic [XW-1:0]          sel_x_s;
    logic [YW-1:0]          sel_y_s;
    logic [CW-1:0]          sel_col_s;

    // Grant generation: locked owner only, otherwise round-robin from ptr+1.
    // Grants only ever go to requesting clients, so any grant is an accept.
    always_comb begin
        grant_s   = '0;
        acc_s     = 1'b0;
        acc_idx_s = '0;
        cand_s    = '0;
`ifdef PIXEL_ARB_LOCK_EN
        if (locked_q) begin
            if (!hold) begin
                grant_s[owner_q] = req[owner_q];
                acc_s            = req[owner_q];
                acc_idx_s        = owner_q;
            end else begin
                grant_s = '0;
            end
        end else
`endif
        if (!hold && (req != '0)) begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                cand_s = PW'((32'(ptr_q) + 32'(k)) % 32'(NUM_CLIENTS));
                if (!acc_s && req[cand_s]) begin
                    grant_s[cand_s] = 1'b1;
                    acc_s           = 1'b1;
                    acc_idx_s       = cand_s;
                end else begin
                    acc_s = acc_s;
                end
            end
        end else begin
            grant_s = '0;
        end
    end

    // Select the winning client's pixel data
    always_comb begin
        sel_x_s   = iX[32'(acc_idx_s)*XW +: XW];
        sel_y_s   = iY[32'(acc_idx_s)*YW +: YW];
        sel_col_s = iColour[32'(acc_idx_s)*CW +: CW];
    end

    // Next-state: capture on accept, strobe only on-screen pixels
    always_comb begin
        ptr_d  = ptr_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        ocol_d = ocol_q;
        plot_d = 1'b0;
        drop_d = drop_q;
        if (acc_s) begin
            ptr_d  = acc_idx_s;
            ox_d   = sel_x_s;
            oy_d   = sel_y_s;
            ocol_d = sel_col_s;
            if (on_screen(sel_x_s, sel_y_s)) begin
                plot_d = 1'b1;
            end else begin
                plot_d = 1'b0;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end else begin
                    drop_d = drop_q;
                end
            end
        end else begin
            plot_d = 1'b0;
        end
    end

`ifdef PIXEL_ARB_LOCK_EN
    // Lock tracking: enter on a locked accept, leave when the owner's lock drops
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        if (locked_q) begin
            if (!lock[owner_q]) begin
                locked_d = 1'b0;
            end else begin
                locked_d = 1'b1;
            end
        end else if (acc_s && lock[acc_idx_s]) begin
            locked_d = 1'b1;
            owner_d  = acc_idx_s;
        end else begin
            locked_d = 1'b0;
        end
    end

    // Lock state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end
`endif

    // Pointer and output registers. The pointer resets to the last client,
    // so client 0 wins the first arbitration.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q  <= PW'(NUM_CLIENTS - 1);
            ox_q   <= '0;
            oy_q   <= '0;
            ocol_q <= '0;
            plot_q <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            ptr_q  <= ptr_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            ocol_q <= ocol_d;
            plot_q <= plot_d;
            drop_q <= drop_d;
        end
    end

    assign grant     = grant_s;
    assign oX        = ox_q;
    assign oY        = oy_q;
    assign oColour   = ocol_q;
    assign oPlot     = plot_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pixel_write_arbiter
//
// Directed self-checking bench for pixel_write_arbiter (4 clients).
// Inputs change 1 time unit after a rising edge. The combinational grant is
// checked 1 unit later. Registered outputs are checked 1 unit after the
// next rising edge. The lock scenario is included when PIXEL_ARB_LOCK_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_pixel_write_arbiter;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 9;

    logic            clock;
    logic            resetn;
    logic            hold;
    logic [N-1:0]    req;
`ifdef PIXEL_ARB_LOCK_EN
    logic [N-1:0]    lock;
`endif
    logic [N*XW-1:0] iX;
    logic [N*YW-1:0] iY;
    logic [N*CW-1:0] iColour;
    logic [N-1:0]    grant;
    logic [XW-1:0]   oX;
    logic [YW-1:0]   oY;
    logic [CW-1:0]   oColour;
    logic            oPlot;
    logic [7:0]      dropCount;

    int tests_run;
    int tests_failed;

    pixel_write_arbiter #(
        .NUM_CLIENTS(N), .XW(XW), .YW(YW), .CW(CW), .XMAX(160), .YMAX(120)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .hold      (hold),
        .req       (req),
`ifdef PIXEL_ARB_LOCK_EN
        .lock      (lock),
`endif
        .iX        (iX),
        .iY        (iY),
        .iColour   (iColour),
        .grant     (grant),
        .oX        (oX),
        .oY        (oY),
        .oColour   (oColour),
        .oPlot     (oPlot),
        .dropCount (dropCount)
    );

    // 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: count it, report on mismatch
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_client(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                              input logic [CW-1:0] c);
        iX[i*XW +: XW]      = x;
        iY[i*YW +: YW]      = y;
        iColour[i*CW +: CW] = c;
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #12;
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn  = 1'b1;
        hold    = 1'b0;
        req     = '0;
`ifdef PIXEL_ARB_LOCK_EN
        lock    = '0;
`endif
        iX      = '0;
        iY      = '0;
        iColour = '0;
        #1;

        // ---- Reset state ----
        do_reset();
        check_eq("rst_oX", 32'(oX), 32'd0);
        check_eq("rst_oY", 32'(oY), 32'd0);
        check_eq("rst_oColour", 32'(oColour), 32'd0);
        check_eq("rst_oPlot", 32'(oPlot), 32'd0);
        check_eq("rst_drop", 32'(dropCount), 32'd0);

        // ---- All four request continuously at (10,10), colour = client+1 ----
        for (int i = 0; i < N; i++) set_client(i, 8'd10, 7'd10, 9'(i + 1));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            tick();
            check_eq("rr_plot", 32'(oPlot), 32'd1);
            check_eq("rr_colour", 32'(oColour), 32'((k % 4) + 1));
        end
        check_eq("rr_oX", 32'(oX), 32'd10);

        // ---- No request: strobe drops, data holds ----
        req = 4'b0000;
        #1;
        check_eq("idle_grant", 32'(grant), 32'd0);
        tick();
        check_eq("idle_plot", 32'(oPlot), 32'd0);
        check_eq("idle_hold_colour", 32'(oColour), 32'd4);

        // ---- Single requester: client 2 ----
        set_client(2, 8'd20, 7'd30, 9'h1C0);
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("single_grant", 32'(grant), 32'b0100);
            tick();
            check_eq("single_oX", 32'(oX), 32'd20);
            check_eq("single_oY", 32'(oY), 32'd30);
            check_eq("single_colour", 32'(oColour), 32'h1C0);
            check_eq("single_plot", 32'(oPlot), 32'd1);
        end

        // ---- Off-screen pixels from client 1 ----
        set_client(1, 8'd160, 7'd5, 9'h0AA);
        req = 4'b0010;
        #1;
        check_eq("off_grant", 32'(grant), 32'b0010);
        tick();
        check_eq("off_plot", 32'(oPlot), 32'd0);
        check_eq("off_oX", 32'(oX), 32'd160);
        check_eq("off_drop1", 32'(dropCount), 32'd1);
        // last on-screen corner
        set_client(1, 8'd159, 7'd119, 9'h011);
        tick();
        check_eq("corner_plot", 32'(oPlot), 32'd1);
        check_eq("corner_drop", 32'(dropCount), 32'd1);
        // y at the bottom edge is off-screen
        set_client(1, 8'd0, 7'd120, 9'h011);
        tick();
        check_eq("yedge_plot", 32'(oPlot), 32'd0);
        check_eq("yedge_drop", 32'(dropCount), 32'd2);
        // 298 more off-screen pixels (300 total) saturate at 255
        set_client(1, 8'd160, 7'd5, 9'h0AA);
        for (int k = 0; k < 298; k++) tick();
        check_eq("sat_drop", 32'(dropCount), 32'd255);
        check_eq("sat_plot", 32'(oPlot), 32'd0);
        req = 4'b0000;

        // ---- hold stalls grants, pointer preserved from reset ----
        do_reset();
        set_client(0, 8'd1, 7'd2, 9'h003);
        set_client(1, 8'd4, 7'd5, 9'h006);
        req  = 4'b0011;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("hold_grant", 32'(grant), 32'd0);
            tick();
            check_eq("hold_plot", 32'(oPlot), 32'd0);
        end
        hold = 1'b0;
        #1;
        check_eq("unhold_grant0", 32'(grant), 32'b0001);
        tick();
        check_eq("unhold_plot", 32'(oPlot), 32'd1);
        check_eq("unhold_oX", 32'(oX), 32'd1);
        check_eq("unhold_grant1", 32'(grant), 32'b0010);
        // hold rising mid-stream: the registered pixel still plots, then stops
        hold = 1'b1;
        #1;
        check_eq("midhold_grant", 32'(grant), 32'd0);
        tick();
        check_eq("midhold_plot", 32'(oPlot), 32'd0);
        hold = 1'b0;
        #1;
        check_eq("after_hold_grant", 32'(grant), 32'b0010);

        // ---- Asynchronous reset while plotting ----
        tick();
        check_eq("pre_arst_plot", 32'(oPlot), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_plot", 32'(oPlot), 32'd0);
        check_eq("arst_oX", 32'(oX), 32'd0);
        check_eq("arst_oY", 32'(oY), 32'd0);
        check_eq("arst_colour", 32'(oColour), 32'd0);
        req = 4'b0000;
        @(posedge clock);
        #1;
        resetn = 1'b1;

`ifdef PIXEL_ARB_LOCK_EN
        // ---- Locked 4-beat burst from client 0 with client 1 competing ----
        do_reset();
        set_client(0, 8'd50, 7'd50, 9'h1FF);
        set_client(1, 8'd60, 7'd60, 9'h100);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            lock = (k < 3) ? 4'b0001 : 4'b0000;
            #1;
            check_eq("lock_grant", 32'(grant), 32'b0001);
            tick();
            check_eq("lock_oX", 32'(oX), 32'd50);
        end
        lock = 4'b0000;
        #1;
        check_eq("unlock_grant", 32'(grant), 32'b0010);
        tick();
        check_eq("unlock_oX", 32'(oX), 32'd60);
        req = 4'b0000;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
